// File: rtl/shift_pkg.sv
// Shared types and sizes for the left lane shifter and its multi-pass sequencer.
package shift_pkg;

  localparam int unsigned LANES    = 8;
  localparam int unsigned LANE_W   = 12;
  localparam int unsigned MAX_STEP = 5;
  localparam int unsigned AMT_W    = 4;
  localparam int unsigned STEP_W   = 3;
  localparam int unsigned WORD_W   = LANES * LANE_W;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Shifts of LANES or more all produce an all-fill word, so clamp there.
  function automatic logic [AMT_W-1:0] eff_amount(input logic [AMT_W-1:0] amt);
    return (amt > AMT_W'(LANES)) ? AMT_W'(LANES) : amt;
  endfunction

  // Largest legal pass toward the remaining amount.
  function automatic logic [STEP_W-1:0] pass_step(input logic [AMT_W-1:0] rem);
    return (rem > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : STEP_W'(rem);
  endfunction

endpackage

// File: rtl/lane_shift_step.sv
// One combinational pass of the left lane shifter: lanes move up by step, vacated lanes take fill.
module lane_shift_step
  import shift_pkg::*;
(
  input  word_t             data,
  input  logic [STEP_W-1:0] step,
  input  lane_t             fill,
  output word_t             shifted_c
);

  always_comb begin
    shifted_c = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (j >= 32'(step)) begin
        shifted_c[j*LANE_W +: LANE_W] = data[(j - 32'(step))*LANE_W +: LANE_W];
      end else begin
        shifted_c[j*LANE_W +: LANE_W] = fill;
      end
    end
  end

endmodule

// File: rtl/shift_left_seq.sv
// Multi-pass sequencer: breaks a 0-15 lane left shift into legal 0-5 lane passes.
module shift_left_seq
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LANE_W-1:0] in_fill,
  input  logic [AMT_W-1:0]  in_amount,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy
);

  state_t             state_q, state_d;
  word_t              data_q, data_d;
  lane_t              fill_q, fill_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [AMT_W-1:0]   amt_eff_c;
  logic [STEP_W-1:0]  step_c;
  word_t              shifted_c;
  logic               in_ready_q, out_valid_q, busy_q;

  assign step_c    = pass_step(rem_q);
  assign amt_eff_c = eff_amount(in_amount);

  lane_shift_step u_step (
    .data      (data_q),
    .step      (step_c),
    .fill      (fill_q),
    .shifted_c (shifted_c)
  );

  // Next-state and datapath selection; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          fill_d  = in_fill;
          rem_d   = amt_eff_c;
          state_d = (amt_eff_c == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        data_d = shifted_c;
        rem_d  = rem_q - AMT_W'(step_c);
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      data_d  = data_q;
      fill_d  = fill_q;
      rem_d   = rem_q;
    end
  end

  // State, datapath and handshake flags; flags are decoded from the next state so they are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      fill_q      <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;

  // The shifter must never see step codes 6 or 7.
  assert property (@(posedge clk) disable iff (!rst_n) step_c <= STEP_W'(MAX_STEP))
    else $error("illegal shifter step code %0d", step_c);

endmodule

// File: tb/tb_shift_left_seq.sv
// Randomized and directed bench for shift_left_seq against a lane-array reference model.
module tb_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [11:0] in_fill;
  logic [3:0]  in_amount;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int max_step = 0;

  shift_left_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_fill   (in_fill),
    .in_amount (in_amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Track the largest step code driven to the shifter while a request is in flight.
  always @(negedge clk) begin
    if (rst_n && busy && !out_valid && int'(dut.step_c) > max_step) max_step = int'(dut.step_c);
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] model(input logic [95:0] d, input logic [11:0] f, input int amt);
    logic [11:0] lanes [8];
    logic [95:0] r;
    int a;
    a = (amt > 8) ? 8 : amt;
    for (int j = 0; j < 8; j++) lanes[j] = (j >= a) ? d[(j-a)*12 +: 12] : f;
    for (int j = 0; j < 8; j++) r[j*12 +: 12] = lanes[j];
    return r;
  endfunction

  function automatic int model_lat(input int amt);
    int a;
    a = (amt > 8) ? 8 : amt;
    return (a == 0) ? 0 : (a + 4) / 5;
  endfunction

  function automatic logic [95:0] ramp_word();
    logic [95:0] w;
    for (int i = 0; i < 8; i++) w[i*12 +: 12] = 12'(i);
    return w;
  endfunction

  // One full transaction: accept, wait for result, optionally stall, then consume.
  task automatic run_req(input string tag, input logic [95:0] d, input logic [11:0] f,
                         input int amt, input int hold);
    int lat;
    logic [95:0] exp_w, first;
    logic stable;
    exp_w = model(d, f, amt);
    @(negedge clk);
    check({tag, "_in_ready"}, 96'(in_ready), 96'(1));
    in_valid  = 1'b1;
    in_data   = d;
    in_fill   = f;
    in_amount = 4'(amt);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 96'(lat), 96'(model_lat(amt)));
    check({tag, "_data"}, out_data, exp_w);
    first  = out_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_data !== first) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 96'(stable), 96'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ret_idle"}, 96'({out_valid, in_ready, busy}), 96'(3'b010));
  endtask

  initial begin
    logic [95:0] ramp;
    ramp      = ramp_word();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_fill   = '0;
    in_amount = '0;
    out_ready = 1'b0;
    #12;
    check("reset_flags", 96'({in_ready, out_valid, busy}), 96'(3'b100));
    check("reset_data", out_data, 96'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_req("amt0", ramp, 12'hFFF, 0, 0);
    run_req("amt3", ramp, 12'hFFF, 3, 0);
    check("amt3_lanes", out_data, {12'h004, 12'h003, 12'h002, 12'h001, 12'h000, {3{12'hFFF}}});
    run_req("amt7", ramp, 12'hFFF, 7, 0);
    check("amt7_lanes", out_data, {12'h000, {7{12'hFFF}}});
    run_req("amt13", ramp, 12'hA5A, 13, 0);
    check("amt13_lanes", out_data, {8{12'hA5A}});
    run_req("bp_amt2", ramp, 12'hFFF, 2, 10);
    run_req("amt8", ramp, 12'h123, 8, 1);
    run_req("amt5", ramp, 12'h0F0, 5, 0);

    // Flush on the first RUN cycle: no result appears.
    @(negedge clk);
    in_valid = 1'b1; in_data = ramp; in_fill = 12'hFFF; in_amount = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 96'({out_valid, in_ready, busy}), 96'(3'b010));
    repeat (3) @(posedge clk);
    #1 check("flush_no_valid", 96'(out_valid), 96'(0));

    // Flush together with in_valid in IDLE: request is not taken.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_amount = 4'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept", 96'({busy, in_ready}), 96'(2'b01));

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    in_valid = 1'b1; in_data = ramp; in_fill = 12'hFFF; in_amount = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_flags", 96'({in_ready, out_valid, busy}), 96'(3'b100));
    check("rst_mid_data", out_data, 96'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      logic [95:0] d;
      d = {$urandom, $urandom, $urandom};
      run_req("rand", d, 12'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    check("step_max", 96'(max_step <= 5), 96'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_left_seq.md
# shift_left_seq

Multi-pass sequencer for the 8-lane × 12-bit left lane shifter. It accepts a 96-bit word, a 12-bit fill lane and a lane shift amount of 0–15 over a valid/ready handshake. It then drives the shifter iteratively with legal step codes (0–5 lanes per pass), feeding each result back into a working register. Its output is a single shifted word on a valid/ready handshake. It sits between the operand-formatting stage and any consumer needing shifts beyond the shifter's legal range.

## Interface
- LANES, 8, number of lanes in the word
- LANE_W, 12, bits per lane
- MAX_STEP, 5, largest legal per-pass lane shift (step codes 6 and 7 are illegal for the shifter)
- AMT_W, 4, width of the requested shift amount
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_data  input  96  word; lane i = bits [12i+11:12i]
- in_fill  input  12  value written into every vacated lane
- in_amount  input  4  lanes to shift toward the MSB
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  96  shifted word
- busy  output  1  high in RUN or DONE

## Operation
- Registers:
  - data_q (96 bits)
  - fill_q (12 bits)
  - rem_q (4 bits, remaining lanes)
  - state (IDLE / RUN / DONE)
- Effective amount a' = min(in_amount, 8). Amounts of 8–15 all yield an all-fill word.
- Per pass, step = min(rem_q, MAX_STEP).
  - data_q <= lane shift of data_q by step. Out lane j takes lane j−step; lanes j < step take fill_q.
  - rem_q <= rem_q − step.
- IDLE:
  - in_ready = 1.
  - On accept: capture data, fill and a'.
  - Go to DONE if a' = 0, else go to RUN.
- RUN:
  - in_ready = 0. One pass per cycle.
  - Go to DONE on the pass where rem_q − step = 0; otherwise stay in RUN.
- DONE:
  - out_valid = 1; out_data = data_q, held stable.
  - Go to IDLE on out_ready.
- flush is sampled each edge and has priority over every transition. It forces IDLE next edge, deasserts out_valid, and discards the request in flight. data_q is left unchanged.
- in_ready does not bypass DONE: a new request is never accepted on the same edge a result is consumed.
- Step code issued to the shifter is always 0–5. Asserting this is mandatory.

## Timing
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid = 0; busy = 0.
  - data_q = 0; fill_q = 0; rem_q = 0.
  - out_data = 0.
- Reset mid-operation drops everything immediately (asynchronous).
- Latency is counted from the accepting edge to the first cycle with out_valid = 1.
  - a' = 0: out_valid high right after the accepting edge, i.e. 0 additional edges.
  - a' > 0: ceil(a'/5) additional edges. Amount 1–5 takes 1 edge; 6–15 take 2 edges.
- Throughput is one request per (latency + 2) cycles when out_ready is held high. This includes the DONE→IDLE return cycle.
- out_ready low in DONE: hold indefinitely with no change to out_data.
- flush together with out_ready in DONE: flush wins and the result is counted as dropped.
- flush together with in_valid in IDLE: the request is not accepted.
- Upper-nibble amounts (8–15) must never issue a third pass.

## Structure
- Shared package shift_pkg:
  - LANES, LANE_W, MAX_STEP
  - typedef lane_t (12 bits), word_t (96 bits)
  - state enum {IDLE, RUN, DONE}
- Sub-module lane_shift_step: purely combinational, word_t × step[2:0] × lane_t → word_t. It implements one legal pass and is instantiated once.
- All sequencing lives in shift_left_seq.

## Test plan
In all scenarios, in_data has lane i = 12'h00i (lanes 7..0 = 007…000) and fill = 12'hFFF unless stated otherwise.
- Amount 0, out_ready = 1: out_valid on the next cycle; out_data = in_data.
- Amount 3: one pass; lanes 7..0 = 004,003,002,001,000,FFF,FFF,FFF; out_valid 1 edge after accept.
- Amount 7: two passes (5 + 2); lanes 7..0 = 000 then FFF×7; latency 2 edges; the step monitor never sees 6 or 7.
- Amount 13 with fill = 12'hA5A: two passes; out_data = {8{12'hA5A}}; no third pass.
- Back-pressure: amount 2, out_ready low for 10 cycles → out_valid and out_data stable, in_ready = 0; out_ready high → IDLE next edge and in_ready = 1.
- flush on the first RUN cycle of amount 9 → IDLE next edge, no out_valid pulse. rst_n low mid-RUN → all outputs at their reset values immediately.
